// File: rtl/llsc_pkg.sv
// Shared encodings and helpers for the LL/SC reservation controller.
package llsc_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_LL   = 2'b01,
    OP_SC   = 2'b10
  } op_type_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LL_REQ  = 3'd1,
    LL_WAIT = 3'd2,
    SC_REQ  = 3'd3,
    RESP    = 3'd4
  } state_e;

  // Write-side payload of the data-bus request.
  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] wdata;
  } mem_wr_t;

  // Writeback value of a store-conditional: 1 on success, 0 on failure.
  function automatic logic [DATA_W-1:0] sc_result(input logic pass);
    return DATA_W'(pass);
  endfunction

endpackage

// File: rtl/ll_sc_ctrl_if.sv
// MEM-stage request, writeback result, data-bus and snoop signals of the LL/SC controller.
interface ll_sc_ctrl_if #(
  parameter int unsigned AW = 32
);
  logic          op_valid;
  logic [1:0]    op_type;
  logic [AW-1:0] op_addr;
  logic [31:0]   op_wdata;
  logic          op_ready;
  logic          stall;
  logic          res_valid;
  logic [31:0]   res_data;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [31:0]   mem_rdata;
  logic          snoop_we;
  logic [AW-1:0] snoop_addr;

  // Controller view.
  modport slave (
    input  op_valid, op_type, op_addr, op_wdata,
    output op_ready, stall, res_valid, res_data,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    input  snoop_we, snoop_addr
  );

  // Pipeline / memory / snoop environment view.
  modport master (
    output op_valid, op_type, op_addr, op_wdata,
    input  op_ready, stall, res_valid, res_data,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    output snoop_we, snoop_addr
  );
endinterface

// File: rtl/ll_link_reg.sv
// Link (reservation) register with prioritised clear/set: clr > snoop hit > set.
// Snoop-based invalidation is compiled in only when LLSC_SNOOP_EN is defined.
module ll_link_reg #(
  parameter int unsigned WAW = 30
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr_i,
  input  logic           set_i,
  input  logic [WAW-1:0] set_addr_i,
  input  logic           snoop_we_i,
  input  logic [WAW-1:0] snoop_word_i,
  output logic           snoop_hit_c,
  output logic           link_valid,
  output logic [WAW-1:0] link_addr
);

  logic           valid_q, valid_d;
  logic [WAW-1:0] addr_q,  addr_d;
  logic           set_hit_c;

`ifdef LLSC_SNOOP_EN
  assign snoop_hit_c = snoop_we_i && (snoop_word_i == addr_q);
  // A foreign write to the word being linked this cycle cancels the new link.
  assign set_hit_c   = snoop_we_i && (snoop_word_i == set_addr_i);
`else
  logic unused_snoop;
  assign unused_snoop = ^{snoop_we_i, snoop_word_i};
  assign snoop_hit_c  = 1'b0;
  assign set_hit_c    = 1'b0;
`endif

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    if (clr_i) begin
      valid_d = 1'b0;
    end else if (set_i) begin
      addr_d  = set_addr_i;
      valid_d = !set_hit_c;
    end else if (snoop_hit_c) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end

  assign link_valid = valid_q;
  assign link_addr  = addr_q;

endmodule

// File: rtl/ll_sc_ctrl.sv
// LL/SC controller: issues LL reads and conditional SC writes on the data bus
// and tracks the reservation. Optional snoop invalidation: LLSC_SNOOP_EN.
module ll_sc_ctrl
  import llsc_pkg::*;
#(
  parameter int unsigned AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  ll_sc_ctrl_if.slave   bus,
  input  logic          excpt,
  output logic          link_valid,
  output logic [AW-3:0] link_addr
);

  localparam int unsigned WAW = AW - 2;

  state_e              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic [AW-1:0]       mem_addr_q, mem_addr_d;
  mem_wr_t             mem_wr_q, mem_wr_d;
  logic                res_valid_q, res_valid_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
  logic                flush_q, flush_d;

  logic [WAW-1:0]      op_word;
  logic                accept_ll_c;
  logic                accept_sc_c;
  logic                sc_pass_c;
  logic                snoop_hit_c;
  logic                link_set_c;
  logic                link_clr_c;
  logic                unused_bits;

  assign op_word     = bus.op_addr[AW-1:2];
  assign unused_bits = ^{bus.op_addr[1:0], bus.snoop_addr[1:0]};

  assign accept_ll_c = (state_q == IDLE) && bus.op_valid && (bus.op_type == OP_LL);
  assign accept_sc_c = (state_q == IDLE) && bus.op_valid && (bus.op_type == OP_SC);
  assign sc_pass_c   = link_valid && (link_addr == op_word) && !excpt && !snoop_hit_c;

  // Every SC consumes the reservation; an exception flushes it.
  assign link_clr_c  = excpt || accept_sc_c;

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wr_q    <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      flush_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wr_q    <= mem_wr_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      flush_q     <= flush_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_ll_c) begin
          state_d = LL_REQ;
        end else if (accept_sc_c) begin
          state_d = sc_pass_c ? SC_REQ : RESP;
        end
      end
      LL_REQ: begin
        // Once granted the read is in flight and must be drained in LL_WAIT.
        if (bus.mem_gnt) begin
          state_d = LL_WAIT;
        end else if (excpt) begin
          state_d = IDLE;
        end
      end
      LL_WAIT: begin
        if (bus.mem_rvalid) begin
          state_d = IDLE;
        end
      end
      SC_REQ: begin
        if (excpt) begin
          state_d = IDLE;
        end else if (bus.mem_gnt) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_wr_d    = mem_wr_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    flush_d     = flush_q;
    link_set_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_ll_c) begin
          mem_req_d   = 1'b1;
          mem_addr_d  = {op_word, 2'b00};
          mem_wr_d.we = 1'b0;
        end else if (accept_sc_c) begin
          if (sc_pass_c) begin
            mem_req_d      = 1'b1;
            mem_addr_d     = {op_word, 2'b00};
            mem_wr_d.we    = 1'b1;
            mem_wr_d.wdata = bus.op_wdata;
          end else begin
            res_valid_d = 1'b1;
            res_data_d  = sc_result(1'b0);
          end
        end
      end
      LL_REQ: begin
        if (bus.mem_gnt || excpt) begin
          mem_req_d = 1'b0;
        end
        if (bus.mem_gnt) begin
          flush_d = excpt;
        end
      end
      LL_WAIT: begin
        if (excpt) begin
          flush_d = 1'b1;
        end
        if (bus.mem_rvalid) begin
          flush_d = 1'b0;
          if (!flush_q && !excpt) begin
            res_valid_d = 1'b1;
            res_data_d  = bus.mem_rdata;
            link_set_c  = 1'b1;
          end
        end
      end
      SC_REQ: begin
        if (bus.mem_gnt || excpt) begin
          mem_req_d = 1'b0;
        end
        if (bus.mem_gnt && !excpt) begin
          res_valid_d = 1'b1;
          res_data_d  = sc_result(1'b1);
        end
      end
      default: ;
    endcase
  end

  ll_link_reg #(
    .WAW (WAW)
  ) u_link (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (link_clr_c),
    .set_i        (link_set_c),
    .set_addr_i   (mem_addr_q[AW-1:2]),
    .snoop_we_i   (bus.snoop_we),
    .snoop_word_i (bus.snoop_addr[AW-1:2]),
    .snoop_hit_c  (snoop_hit_c),
    .link_valid   (link_valid),
    .link_addr    (link_addr)
  );

  assign bus.op_ready  = (state_q == IDLE);
  assign bus.stall     = (bus.op_valid && (bus.op_type != OP_NONE)) || (state_q != IDLE);
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_wr_q.we;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wr_q.wdata;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;

endmodule

// File: tb/tb_ll_sc_ctrl.sv
// Directed bench for ll_sc_ctrl with a result scoreboard and a link-state model.
module tb_ll_sc_ctrl;

  logic        clk;
  logic        rst;
  logic        excpt;
  logic        link_valid;
  logic [29:0] link_addr;

  int unsigned total;
  int unsigned passed;
  int unsigned res_cnt;
  int unsigned exp_res_cnt;
  logic [31:0] sb[$];

  // Reference model of the reservation.
  logic        m_lv;
  logic [29:0] m_la;

  ll_sc_ctrl_if #(.AW(32)) bus ();

  ll_sc_ctrl #(.AW(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .excpt      (excpt),
    .link_valid (link_valid),
    .link_addr  (link_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Result monitor: every res_valid pulse must match the oldest expectation.
  initial begin
    logic [31:0] exp;
    forever begin
      @(negedge clk);
      if (!rst && bus.res_valid === 1'b1) begin
        res_cnt++;
        if (sb.size() == 0) begin
          total++;
          $error("FAIL res_unexpected: observed res_data %0h required no result", bus.res_data);
        end else begin
          exp = sb.pop_front();
          check("res_data", 64'(bus.res_data), 64'(exp));
        end
      end
    end
  end

  task automatic drive_op(input logic [1:0] t, input logic [31:0] a, input logic [31:0] wd);
    bus.op_valid = 1'b1;
    bus.op_type  = t;
    bus.op_addr  = a;
    bus.op_wdata = wd;
    tick();
    bus.op_valid = 1'b0;
    bus.op_type  = 2'b00;
  endtask

  task automatic do_ll(input logic [31:0] a, input logic [31:0] data, input int gnt_dly,
                       input bit flush);
    drive_op(2'b01, a, 32'h0);
    check("ll_mem_req", 64'(bus.mem_req), 64'd1);
    check("ll_mem_we", 64'(bus.mem_we), 64'd0);
    check("ll_mem_addr", 64'(bus.mem_addr), 64'({a[31:2], 2'b00}));
    check("ll_stall", 64'(bus.stall), 64'd1);
    for (int i = 0; i < gnt_dly; i++) begin
      tick();
      check("ll_req_hold", 64'({bus.mem_req, bus.mem_addr}), 64'({1'b1, a[31:2], 2'b00}));
    end
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    check("ll_req_drop", 64'(bus.mem_req), 64'd0);
    if (flush) begin
      excpt = 1'b1;
      m_lv  = 1'b0;
      tick();
      excpt = 1'b0;
    end
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = data;
    if (!flush) begin
      sb.push_back(data);
      exp_res_cnt++;
      m_lv = 1'b1;
      m_la = a[31:2];
    end
    tick();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    tick();
    check("ll_link_valid", 64'(link_valid), 64'(m_lv));
    if (m_lv) check("ll_link_addr", 64'(link_addr), 64'(m_la));
  endtask

  task automatic do_sc(input logic [31:0] a, input logic [31:0] wd, input int gnt_dly);
    bit pass;
    pass = m_lv && (m_la == a[31:2]);
    sb.push_back(pass ? 32'h1 : 32'h0);
    exp_res_cnt++;
    m_lv = 1'b0;
    drive_op(2'b10, a, wd);
    check("sc_mem_req", 64'(bus.mem_req), 64'(pass));
    check("sc_link_cleared", 64'(link_valid), 64'd0);
    if (pass) begin
      check("sc_mem_we", 64'(bus.mem_we), 64'd1);
      check("sc_mem_wdata", 64'(bus.mem_wdata), 64'(wd));
      check("sc_mem_addr", 64'(bus.mem_addr), 64'({a[31:2], 2'b00}));
      for (int i = 0; i < gnt_dly; i++) begin
        tick();
        check("sc_req_hold", 64'({bus.mem_req, bus.mem_we, bus.mem_wdata}), 64'({2'b11, wd}));
      end
      bus.mem_gnt = 1'b1;
      tick();
      bus.mem_gnt = 1'b0;
      check("sc_res_valid", 64'(bus.res_valid), 64'd1);
    end else begin
      check("sc_fail_latency", 64'(bus.res_valid), 64'd1);
    end
    tick();
    check("sc_res_pulse", 64'(bus.res_valid), 64'd0);
  endtask

  task automatic do_snoop(input logic [31:0] a);
    bus.snoop_we   = 1'b1;
    bus.snoop_addr = a;
`ifdef LLSC_SNOOP_EN
    if (a[31:2] == m_la) m_lv = 1'b0;
`endif
    tick();
    bus.snoop_we   = 1'b0;
    bus.snoop_addr = 32'h0;
  endtask

  initial begin
    total = 0; passed = 0; res_cnt = 0; exp_res_cnt = 0;
    m_lv = 1'b0; m_la = '0;
    rst = 1'b1; excpt = 1'b0;
    bus.op_valid = 1'b0; bus.op_type = 2'b00; bus.op_addr = 32'h0; bus.op_wdata = 32'h0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
    bus.snoop_we = 1'b0; bus.snoop_addr = 32'h0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state.
    check("rst_op_ready", 64'(bus.op_ready), 64'd1);
    check("rst_stall", 64'(bus.stall), 64'd0);
    check("rst_mem", 64'({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata[29:0]}), 64'd0);
    check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    check("rst_res", 64'({bus.res_valid, bus.res_data}), 64'd0);
    check("rst_link", 64'({link_valid, link_addr}), 64'd0);

    // Unknown op type stalls but is not accepted.
    bus.op_valid = 1'b1; bus.op_type = 2'b11; bus.op_addr = 32'h100;
    #1;
    check("noop_stall", 64'(bus.stall), 64'd1);
    tick();
    bus.op_valid = 1'b0; bus.op_type = 2'b00;
    check("noop_ignored", 64'({bus.op_ready, bus.mem_req}), 64'({1'b1, 1'b0}));

    // LL with grant at +1, data at +2.
    do_ll(32'h100, 32'hDEADBEEF, 0, 1'b0);
    check("ll_link_addr_40", 64'(link_addr), 64'h40);

    // LL then matching SC with a delayed grant.
    do_sc(32'h100, 32'h5, 2);

    // SC with no link, then LL 0x100 and SC to a different word.
    do_sc(32'h100, 32'h7, 0);
    do_ll(32'h100, 32'h12345678, 1, 1'b0);
    do_sc(32'h104, 32'h9, 0);

    // Foreign write to the linked word (byte offset ignored).
    do_ll(32'h100, 32'hCAFEF00D, 0, 1'b0);
    do_snoop(32'h102);
    do_sc(32'h100, 32'hA, 0);

    // Exception during LL_WAIT: data discarded, no link, following SC fails.
    do_ll(32'h100, 32'h0BADF00D, 0, 1'b1);
    check("excpt_wait_no_res", 64'(res_cnt), 64'(exp_res_cnt));
    do_sc(32'h100, 32'hB, 0);

    // Exception during LL_REQ drops the request.
    do_ll(32'h200, 32'h11111111, 0, 1'b0);
    drive_op(2'b01, 32'h300, 32'h0);
    excpt = 1'b1;
    m_lv  = 1'b0;
    tick();
    excpt = 1'b0;
    check("excpt_req_drop", 64'({bus.mem_req, bus.op_ready, link_valid}), 64'({1'b0, 1'b1, 1'b0}));

    // Reset while the SC write is waiting for grant.
    do_ll(32'h100, 32'h22222222, 0, 1'b0);
    drive_op(2'b10, 32'h100, 32'hC);
    check("rst_sc_req", 64'(bus.mem_req), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_lv = 1'b0; m_la = '0;
    check("rst_mid_mem_req", 64'(bus.mem_req), 64'd0);
    check("rst_mid_idle", 64'(bus.op_ready), 64'd1);
    check("rst_mid_link", 64'(link_valid), 64'd0);

    repeat (3) tick();
    check("sb_drained", 64'(sb.size()), 64'd0);
    check("res_count", 64'(res_cnt), 64'(exp_res_cnt));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ll_sc_ctrl.md
LL_SC_CTRL -- requirements
Module: ll_sc_ctrl

Interface
REQ-001 SHALL have parameter AW, default 32, meaning the address width.
REQ-002 SHALL have port clk, input, 1 bit: the clock.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have ports op_valid (input, 1), op_type (input, 2: 01 LL, 10 SC, others no-op), op_addr (input, AW) and op_wdata (input, 32): the MEM-stage request.
REQ-005 SHALL have ports op_ready (output, 1) and stall (output, 1): op_ready = accept; stall = pipeline hold.
REQ-006 SHALL have ports res_valid (output, 1) and res_data (output, 32): the writeback result.
REQ-007 SHALL have ports mem_req, mem_we (output, 1), mem_addr (output, AW), mem_wdata (output, 32), mem_gnt, mem_rvalid (input, 1) and mem_rdata (input, 32): the data-bus master.
REQ-008 SHALL have port excpt, input, 1 bit: exception/ERET flush.
REQ-009 SHALL have ports snoop_we (input, 1) and snoop_addr (input, AW): foreign-write snoop.
REQ-010 SHALL have ports link_valid (output, 1) and link_addr (output, AW-2): link state visible to CP0.

Function
REQ-011 SHALL implement FSM states IDLE, LL_REQ, LL_WAIT, SC_REQ, RESP; op_ready = (state==IDLE) and stall = op_valid&&op_type!=00 || state!=IDLE.
REQ-012 SHALL accept an op in IDLE when op_valid and op_type is 01 or 10; no-op types are ignored.
REQ-013 SHALL ignore op_addr[1:0]; the word address is op_addr[AW-1:2].
REQ-014 SHALL, on LL accept, enter LL_REQ and drive mem_req=1, mem_we=0, mem_addr registered, until mem_gnt; then enter LL_WAIT until mem_rvalid.
REQ-015 SHALL, on the mem_rvalid cycle, pulse res_valid one cycle later with res_data=mem_rdata, set link_valid=1, load link_addr, and return to IDLE.
REQ-016 SHALL evaluate SC success at accept: link_valid && link_addr==op word address && no excpt or snoop hit that cycle.
REQ-017 SHALL, on SC success, enter SC_REQ with mem_req=1, mem_we=1 and mem_wdata=op_wdata until mem_gnt, then RESP with res_data=32'h1.
REQ-018 SHALL, on SC failure, make no bus access and go to RESP with res_data=32'h0; result latency is 1 cycle after accept.
REQ-019 SHALL clear link_valid on every SC accept, pass or fail.
REQ-020 SHALL hold RESP for one cycle only: res_valid=1, then IDLE.
REQ-021 SHALL apply link clear priority rst > excpt > snoop hit > LL set; a snoop hit on the same word in the LL rvalid cycle leaves the link clear.
REQ-022 SHALL, on excpt in LL_REQ/SC_REQ, drop mem_req and return to IDLE with no res_valid.
REQ-023 SHALL, on excpt in LL_WAIT, wait for mem_rvalid, discard the data, set no link and emit no res_valid.
REQ-024 SHALL hold mem_addr, mem_we and mem_wdata stable while mem_req=1 and mem_gnt=0.

Reset
REQ-025 SHALL on rst go to state IDLE with link_valid=0, link_addr=0, res_valid=0, res_data=0, mem_req=0, mem_we=0, mem_addr=0 and mem_wdata=0.
REQ-026 SHALL, on rst mid-operation, abandon any bus handshake immediately.

Configuration
REQ-027 SHALL provide macro LLSC_SNOOP_EN: when defined, snoop_we && snoop_addr[AW-1:2]==link_addr clears link_valid.
REQ-028 SHALL, when LLSC_SNOOP_EN is undefined, ignore the snoop ports, so only SC, excpt and rst clear the link.

Structure
REQ-029 SHALL place op_type encodings (OP_NONE, OP_LL, OP_SC) and FSM state encodings in shared package llsc_pkg.
REQ-030 SHALL implement the link register with prioritised set/clear as sub-module ll_link_reg.

Verification
REQ-031 SHALL cover LL 0x100 with gnt at +1 and rvalid at +2 carrying 0xDEADBEEF -> res_data=0xDEADBEEF, link_valid=1, link_addr=0x40.
REQ-032 SHALL cover LL 0x100 then SC 0x100 with wdata 0x5 -> mem_we=1 with wdata 0x5, res_data=1, link_valid=0.
REQ-033 SHALL cover LL 0x100 then SC 0x104 -> no mem_req, res_data=0 one cycle after accept.
REQ-034 SHALL cover LL 0x100, then snoop write 0x102, then SC 0x100 -> res_data=0 with LLSC_SNOOP_EN defined, res_data=1 without it.
REQ-035 SHALL cover LL 0x100 with excpt asserted during LL_WAIT -> no res_valid, link_valid=0; a following SC fails.
REQ-036 SHALL cover rst asserted in SC_REQ while gnt is held low -> next cycle state IDLE, mem_req=0, link_valid=0.
